// File: rtl/serial_tx.sv
// Frame transmitter: start bit, DATA_W bits LSB first, stop bit, each CLKS_PER_BIT cycles.
// Line falls one cycle after the handshake; ready_o only in IDLE, valid_i ignored while busy.
module serial_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              tx_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int BW = $clog2(CLKS_PER_BIT + 1);
   localparam int IW = $clog2(DATA_W + 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state, state_nx;
   logic [BW-1:0]     baud, baud_nx;
   logic [IW-1:0]     bit_idx, bit_nx;
   logic [DATA_W-1:0] shreg, shreg_nx;
   logic              tx_nx;
   logic              done_nx;
   logic              baud_end;

   assign baud_end = (baud == BAUD_LAST);

   always_comb begin
      state_nx = state;
      baud_nx  = baud;
      bit_nx   = bit_idx;
      shreg_nx = shreg;
      case (state)
         IDLE: begin
            if (valid_i && ready_o) begin
               shreg_nx = data_i;
               baud_nx  = '0;
               bit_nx   = '0;
               state_nx = START;
            end
         end
         START: begin
            if (baud_end) begin
               baud_nx  = '0;
               state_nx = DATA;
            end else begin
               baud_nx = baud + BW'(1);
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_nx  = '0;
               shreg_nx = shreg >> 1;
               bit_nx   = bit_idx + IW'(1);
               if (bit_idx == BIT_LAST) begin
                  state_nx = STOP;
               end
            end else begin
               baud_nx = baud + BW'(1);
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_nx  = '0;
               state_nx = IDLE;
            end else begin
               baud_nx = baud + BW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase

      // Outputs are computed from the next state so they can be registered without lag.
      case (state_nx)
         START:   tx_nx = 1'b0;
         DATA:    tx_nx = shreg_nx[0];
         default: tx_nx = 1'b1;
      endcase
      done_nx = (state_nx == STOP) && (baud_nx == BAUD_LAST);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx_o    <= 1'b1;
         ready_o <= 1'b1;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
      end else begin
         state   <= state_nx;
         baud    <= baud_nx;
         bit_idx <= bit_nx;
         shreg   <= shreg_nx;
         tx_o    <= tx_nx;
         ready_o <= (state_nx == IDLE);
         busy_o  <= (state_nx != IDLE);
         done_o  <= done_nx;
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (4 and 1 clocks per bit), expected line bits queued at send time.
module tb_serial_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid;
   logic       sel;
   logic [7:0] data;

   logic valid_a, ready_a, tx_a, busy_a, done_a;
   logic valid_b, ready_b, tx_b, busy_b, done_b;
   logic ready_m, tx_m, busy_m, done_m;

   int   checks = 0;
   int   errors = 0;
   logic exp_q[$];
   int   waited;

   always #5 clk = ~clk;

   assign valid_a = valid & ~sel;
   assign valid_b = valid & sel;
   assign ready_m = sel ? ready_b : ready_a;
   assign tx_m    = sel ? tx_b    : tx_a;
   assign busy_m  = sel ? busy_b  : busy_a;
   assign done_m  = sel ? done_b  : done_a;

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
      .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid_a),
      .ready_o(ready_a), .tx_o(tx_a), .busy_o(busy_a), .done_o(done_a)
   );

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut_b (
      .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid_b),
      .ready_o(ready_b), .tx_o(tx_b), .busy_o(busy_b), .done_o(done_b)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_tx"},    tx_m,    1);
      chk({tag, "_ready"}, ready_m, 1);
      chk({tag, "_busy"},  busy_m,  0);
      chk({tag, "_done"},  done_m,  0);
   endtask

   task automatic send(input logic [7:0] d, input bit hold, output int wcnt);
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
      exp_q.push_back(1'b1);
      valid = 1'b1;
      data  = d;
      wcnt  = 0;
      while (!ready_m && wcnt < 200) begin
         tick();
         wcnt++;
      end
      if (!ready_m) chk("hs_timeout", ready_m, 1);
      tick();
      if (!hold) valid = 1'b0;
   endtask

   // Called on the first cycle after the handshake edge; ends on the idle cycle after the frame.
   task automatic monitor(input string tag, input int poke_bit);
      int   c;
      logic e;
      c = sel ? 1 : 4;
      for (int b = 0; b < 10; b++) begin
         if (exp_q.size() == 0) begin
            chk({tag, "_underflow"}, exp_q.size(), 1);
            e = 1'b1;
         end else begin
            e = exp_q.pop_front();
         end
         for (int k = 0; k < c; k++) begin
            chk($sformatf("%s_b%0d_c%0d_tx", tag, b, k), tx_m, e);
            chk($sformatf("%s_b%0d_c%0d_busy", tag, b, k), busy_m, 1);
            chk($sformatf("%s_b%0d_c%0d_ready", tag, b, k), ready_m, 0);
            chk($sformatf("%s_b%0d_c%0d_done", tag, b, k), done_m, (b == 9 && k == c - 1));
            if (b == poke_bit && k == 0) begin
               valid = 1'b1;
               data  = 8'h3C;
            end
            if (b == poke_bit && k == 1) valid = 1'b0;
            tick();
         end
      end
      chk_idle({tag, "_after"});
   endtask

   initial begin
      rst   = 1'b1;
      valid = 1'b1;
      data  = 8'hFF;
      sel   = 1'b0;

      // Reset held for 3 cycles with valid asserted: nothing may start.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_idle($sformatf("rst%0d_a", i));
         chk($sformatf("rst%0d_b_tx", i), tx_b, 1);
         chk($sformatf("rst%0d_b_ready", i), ready_b, 1);
      end
      rst   = 1'b0;
      valid = 1'b0;
      tick();
      chk_idle("post_rst");

      send(8'hA5, 1'b0, waited);
      monitor("a5", -1);

      send(8'hA5, 1'b0, waited);
      monitor("a5_ign", 3);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("ign_idle%0d_busy", i), busy_m, 0);
         chk($sformatf("ign_idle%0d_tx", i), tx_m, 1);
         tick();
      end

      send(8'h00, 1'b1, waited);
      monitor("b2b_00", -1);
      send(8'hFF, 1'b0, waited);
      chk("b2b_gap_wait", waited, 0);
      monitor("b2b_ff", -1);

      // Abort a frame during data bit 3.
      send(8'hC3, 1'b0, waited);
      exp_q.delete();
      repeat (17) tick();
      chk("abort_busy_before", busy_m, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_idle("abort_rst");
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("abort_idle%0d_done", i), done_m, 0);
         chk($sformatf("abort_idle%0d_tx", i), tx_m, 1);
      end
      send(8'h5A, 1'b0, waited);
      monitor("after_abort_5a", -1);

      sel = 1'b1;
      tick();
      chk_idle("minbaud_pre");
      send(8'h81, 1'b0, waited);
      monitor("minbaud_81", -1);

      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
